// File: rtl/block_pkg.sv
// Shared types for the vector feeder and its dot-product consumer.
package block_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } feed_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BLOCK_SIZE_DEF = 3;

  function automatic int unsigned idx_width(input int unsigned bs);
    return $clog2(bs + 1);
  endfunction

  localparam int unsigned IDX_W = idx_width(BLOCK_SIZE_DEF);

  // Consumer side: one element product
  localparam int unsigned PROD_W = 2 * DATA_WIDTH_DEF;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/feeder_buf.sv
// One A/B vector register pair with write-at-index, clear, bulk load and full flag.
module feeder_buf
  import block_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic                  wr_last_i,
  input  logic [DATA_WIDTH-1:0] wr_a_i,
  input  logic [DATA_WIDTH-1:0] wr_b_i,
  input  logic                  ld_en_i,
  input  logic [DATA_WIDTH-1:0] ld_a_i  [BLOCK_SIZE],
  input  logic [DATA_WIDTH-1:0] ld_b_i  [BLOCK_SIZE],
  output logic [DATA_WIDTH-1:0] a_o     [BLOCK_SIZE],
  output logic [DATA_WIDTH-1:0] b_o     [BLOCK_SIZE],
  output logic [DATA_WIDTH-1:0] nxt_a_c [BLOCK_SIZE],
  output logic [DATA_WIDTH-1:0] nxt_b_c [BLOCK_SIZE],
  output logic                  full_o,
  output logic                  done_c
);

  localparam int unsigned IW = idx_width(BLOCK_SIZE);

  logic [IW-1:0]         idx_q;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] a_q [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] b_q [BLOCK_SIZE];

  // Contents as they will be after this cycle's write
  always_comb begin
    done_c = wr_en_i && ((idx_q == IW'(BLOCK_SIZE - 1)) || wr_last_i);
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      nxt_a_c[i] = (wr_en_i && (idx_q == IW'(i))) ? wr_a_i : a_q[i];
      nxt_b_c[i] = (wr_en_i && (idx_q == IW'(i))) ? wr_b_i : b_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (clr_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (ld_en_i) begin
      idx_q  <= '0;
      full_q <= 1'b1;
      a_q    <= ld_a_i;
      b_q    <= ld_b_i;
    end else if (wr_en_i) begin
      idx_q  <= done_c ? '0 : idx_q + IW'(1);
      full_q <= full_q | done_c;
      a_q    <= nxt_a_c;
      b_q    <= nxt_b_c;
    end
  end

  assign a_o    = a_q;
  assign b_o    = b_q;
  assign full_o = full_q;

endmodule

// File: rtl/block_feeder.sv
// Assembles streamed A/B operand pairs into zero-padded vectors for a dot-product stage.
// Define BLOCK_FEEDER_DBUF_EN to fill a second buffer while a vector is presented.
module block_feeder
  import block_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] A [0:BLOCK_SIZE-1],
  output logic [DATA_WIDTH-1:0] B [0:BLOCK_SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           vec_count
);

  localparam int unsigned CNT_W = 16;

  feed_state_e      state_q, state_d;
  logic             ov_q, ov_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c, hand_c;

  assign accept_c = in_valid && rdy_q;
  assign hand_c   = ov_q && out_ready;

`ifdef BLOCK_FEEDER_DBUF_EN
  logic                  fb_full, fb_done_c, move_c, fb_full_d;
  logic [DATA_WIDTH-1:0] fb_nxt_a [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] fb_nxt_b [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_fa [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_fb [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_pa [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_pb [BLOCK_SIZE];
  logic                  unused_pfull, unused_pdone;

  feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_fill (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (move_c),
    .wr_en_i   (accept_c),
    .wr_last_i (in_last),
    .wr_a_i    (in_a),
    .wr_b_i    (in_b),
    .ld_en_i   (1'b0),
    .ld_a_i    (fb_nxt_a),
    .ld_b_i    (fb_nxt_b),
    .a_o       (unused_fa),
    .b_o       (unused_fb),
    .nxt_a_c   (fb_nxt_a),
    .nxt_b_c   (fb_nxt_b),
    .full_o    (fb_full),
    .done_c    (fb_done_c)
  );

  // Presentation buffer takes the fill buffer including the pair landing this cycle
  feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_pres (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (hand_c && !move_c),
    .wr_en_i   (1'b0),
    .wr_last_i (1'b0),
    .wr_a_i    (DATA_WIDTH'(0)),
    .wr_b_i    (DATA_WIDTH'(0)),
    .ld_en_i   (move_c),
    .ld_a_i    (fb_nxt_a),
    .ld_b_i    (fb_nxt_b),
    .a_o       (A),
    .b_o       (B),
    .nxt_a_c   (unused_pa),
    .nxt_b_c   (unused_pb),
    .full_o    (unused_pfull),
    .done_c    (unused_pdone)
  );

  always_comb begin
    move_c    = ((state_q == FILL) || hand_c) && (fb_full || fb_done_c);
    fb_full_d = !move_c && (fb_full || fb_done_c);
    ov_d      = ov_q;
    if (move_c)      ov_d = 1'b1;
    else if (hand_c) ov_d = 1'b0;
    state_d   = ov_d ? PRESENT : FILL;
    rdy_d     = !(fb_full_d && ov_d);
  end
`else
  logic                  buf_done_c, unused_full;
  logic [DATA_WIDTH-1:0] zero_v    [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_na [BLOCK_SIZE];
  logic [DATA_WIDTH-1:0] unused_nb [BLOCK_SIZE];

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) zero_v[i] = '0;
  end

  feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (hand_c),
    .wr_en_i   (accept_c),
    .wr_last_i (in_last),
    .wr_a_i    (in_a),
    .wr_b_i    (in_b),
    .ld_en_i   (1'b0),
    .ld_a_i    (zero_v),
    .ld_b_i    (zero_v),
    .a_o       (A),
    .b_o       (B),
    .nxt_a_c   (unused_na),
    .nxt_b_c   (unused_nb),
    .full_o    (unused_full),
    .done_c    (buf_done_c)
  );

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    case (state_q)
      FILL: if (buf_done_c) begin
        state_d = PRESENT;
        ov_d    = 1'b1;
      end
      PRESENT: if (hand_c) begin
        state_d = FILL;
        ov_d    = 1'b0;
      end
      default: state_d = FILL;
    endcase
    rdy_d = (state_d == FILL);
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
      if (hand_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = ov_q;
  assign in_ready  = rdy_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_block_feeder.sv
// Directed self-checking bench for block_feeder (DATA_WIDTH=8, BLOCK_SIZE=3).
module tb_block_feeder;

  logic       clock;
  logic       reset;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_a, in_b;
  logic [7:0] A [0:2];
  logic [7:0] B [0:2];
  logic       out_valid, out_ready;
  logic [15:0] vec_count;

  int n_asrt = 0;
  int n_fail = 0;

  block_feeder #(.DATA_WIDTH(8), .BLOCK_SIZE(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vec_count (vec_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] ea [3], input logic [7:0] eb [3]);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.A[%0d]", tag, i), 32'(A[i]), 32'(ea[i]));
      check($sformatf("%s.B[%0d]", tag, i), 32'(B[i]), 32'(eb[i]));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int hands;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #2;
    // Reset state
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.in_ready", 32'(in_ready), 32'h0);
    check("rst.vec_count", 32'(vec_count), 32'h0);
    check_vec("rst", '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0});
    step();
    step();
    reset = 1'b1;
    step();
    check("post_rst.in_ready", 32'(in_ready), 32'h1);

    // Full vector, consecutive cycles
    push(8'd1, 8'd4, 1'b0);
    check("full.ov_mid", 32'(out_valid), 32'h0);
    push(8'd2, 8'd5, 1'b0);
    push(8'd3, 8'd6, 1'b0);
    check("full.out_valid", 32'(out_valid), 32'h1);
    check_vec("full", '{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6});
`ifndef BLOCK_FEEDER_DBUF_EN
    check("full.in_ready", 32'(in_ready), 32'h0);
`endif
    check("full.cnt_before", 32'(vec_count), 32'h0);
    step();
    check("full.cnt_after", 32'(vec_count), 32'h1);
    check("full.ov_after", 32'(out_valid), 32'h0);
    check_vec("cleared", '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0});

    // in_last with no accept is ignored
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    check("idle_last.ov", 32'(out_valid), 32'h0);

    // Short vector zero-padded
    push(8'd7, 8'd9, 1'b1);
    check("short.out_valid", 32'(out_valid), 32'h1);
    check_vec("short", '{8'd7, 8'd0, 8'd0}, '{8'd9, 8'd0, 8'd0});
    step();
    check("short.cnt", 32'(vec_count), 32'h2);

    // in_last on the final position acts like a full vector
    push(8'd1, 8'd1, 1'b0);
    push(8'd2, 8'd2, 1'b0);
    push(8'd3, 8'd3, 1'b1);
    check_vec("lastfull", '{8'd1, 8'd2, 8'd3}, '{8'd1, 8'd2, 8'd3});
    step();
    check("lastfull.cnt", 32'(vec_count), 32'h3);

    // Backpressure hold
    out_ready = 1'b0;
    push(8'd10, 8'd20, 1'b0);
    push(8'd11, 8'd21, 1'b0);
    push(8'd12, 8'd22, 1'b0);
    for (int k = 0; k < 5; k++) begin
`ifndef BLOCK_FEEDER_DBUF_EN
      in_valid = 1'b1;
      in_a     = 8'hEE;
      in_b     = 8'hEE;
      in_last  = 1'b1;
`endif
      step();
      check($sformatf("hold%0d.ov", k), 32'(out_valid), 32'h1);
`ifndef BLOCK_FEEDER_DBUF_EN
      check($sformatf("hold%0d.rdy", k), 32'(in_ready), 32'h0);
`endif
      check_vec($sformatf("hold%0d", k), '{8'd10, 8'd11, 8'd12}, '{8'd20, 8'd21, 8'd22});
      check($sformatf("hold%0d.cnt", k), 32'(vec_count), 32'h3);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    check("hold.cnt_after", 32'(vec_count), 32'h4);
    check("hold.ov_after", 32'(out_valid), 32'h0);
    check_vec("hold_clr", '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0});

    // Reset mid-fill discards partial vector
    push(8'd1, 8'd1, 1'b0);
    push(8'd2, 8'd2, 1'b0);
    check_vec("partial", '{8'd1, 8'd2, 8'd0}, '{8'd1, 8'd2, 8'd0});
    reset = 1'b0;
    #1;
    check("mid_rst.ov", 32'(out_valid), 32'h0);
    check("mid_rst.rdy", 32'(in_ready), 32'h0);
    check("mid_rst.cnt", 32'(vec_count), 32'h0);
    check_vec("mid_rst", '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0});
    step();
    reset = 1'b1;
    step();
    check("rerst.rdy", 32'(in_ready), 32'h1);
    push(8'd5, 8'd6, 1'b0);
    push(8'd7, 8'd8, 1'b0);
    check("fresh.ov_mid", 32'(out_valid), 32'h0);
    push(8'd9, 8'd10, 1'b0);
    check("fresh.ov", 32'(out_valid), 32'h1);
    check_vec("fresh", '{8'd5, 8'd7, 8'd9}, '{8'd6, 8'd8, 8'd10});
    step();
    check("fresh.cnt", 32'(vec_count), 32'h1);

    // Counter wrap
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    push(8'd3, 8'd3, 1'b1);
    step();
    check("wrap.ffff", 32'(vec_count), 32'hFFFF);
    push(8'd4, 8'd4, 1'b1);
    step();
    check("wrap.zero", 32'(vec_count), 32'h0);

`ifdef BLOCK_FEEDER_DBUF_EN
    // Continuous stream: 12 pairs -> 4 vectors, in_ready never drops
    hands = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_a     = 8'(i + 1);
      in_b     = 8'(i + 101);
      in_last  = 1'b0;
      step();
      if (out_valid) hands++;
      check($sformatf("stream%0d.rdy", i), 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) hands++;
    end
    check("stream.vectors", 32'(hands), 32'd4);
    check("stream.cnt", 32'(vec_count), 32'd4);
`else
    hands = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/block_feeder.md
BLOCK_FEEDER -- requirements
Module: block_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of one operand element.
REQ-002 Parameter BLOCK_SIZE, default 3, sets the elements per vector; legal range is 1..64.
REQ-003 Port clock, input, 1 bit: clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-007 Port in_a, input, DATA_WIDTH bits: A element.
REQ-008 Port in_b, input, DATA_WIDTH bits: B element.
REQ-009 Port in_last, input, 1 bit: the accepted pair is the final pair of a short vector.
REQ-010 Port A, output, unpacked array [0:BLOCK_SIZE-1] of DATA_WIDTH bits: assembled A vector.
REQ-011 Port B, output, unpacked array [0:BLOCK_SIZE-1] of DATA_WIDTH bits: assembled B vector.
REQ-012 Port out_valid, output, 1 bit: A and B hold a complete vector.
REQ-013 Port out_ready, input, 1 bit: the downstream dot-product stage consumes the vector.
REQ-014 Port vec_count, output, 16 bits: number of vectors delivered, wrapping.

Function
REQ-015 An input accept occurs when in_valid && in_ready; an output handoff occurs when out_valid && out_ready.
REQ-016 The block SHALL have two states, FILL and PRESENT, plus a fill index idx of width clog2(BLOCK_SIZE+1).
REQ-017 In FILL, in_ready=1, out_valid=0, and the k-th accept of the vector writes in_a/in_b to position k (k starts at 0).
REQ-018 An accept at idx==BLOCK_SIZE-1, or any accept with in_last=1, SHALL move the FSM to PRESENT on the next edge.
REQ-019 In that case out_valid=1 in the cycle following the accept (1-cycle latency).
REQ-020 Positions not written before an in_last accept SHALL read 0 in both A and B, so the short vector is zero-padded.
REQ-021 An in_last accept at idx==BLOCK_SIZE-1 behaves identically to a full vector.
REQ-022 in_last SHALL be ignored when no accept occurs.
REQ-023 In PRESENT, A, B and out_valid SHALL be held stable until handoff.
REQ-024 On handoff the FSM returns to FILL with idx=0 and all positions cleared to 0.
REQ-025 vec_count increments by 1 on each handoff and wraps from 0xFFFF to 0x0000.
REQ-026 Without BLOCK_FEEDER_DBUF_EN, in_ready=0 throughout PRESENT.
REQ-027 An element product width of 2*DATA_WIDTH is the consumer's concern; the feeder performs no arithmetic on data.

Reset
REQ-028 On reset low the block SHALL asynchronously enter FILL.
REQ-029 Reset values: idx=0, all A/B positions=0, out_valid=0, vec_count=0, in_ready=0 while reset is asserted.
REQ-030 Reset mid-fill or mid-PRESENT SHALL discard the partial or pending vector without a handoff.

Configuration
REQ-031 The macro BLOCK_FEEDER_DBUF_EN SHALL select double buffering.
REQ-032 With BLOCK_FEEDER_DBUF_EN, a second fill buffer accepts pairs while PRESENT holds the first, so in_ready=1 unless the fill buffer is complete and the presented vector is unconsumed.
REQ-033 With BLOCK_FEEDER_DBUF_EN, on handoff a complete fill buffer is presented on the next cycle with out_valid staying 1, sustaining 1 pair per cycle.
REQ-034 With BLOCK_FEEDER_DBUF_EN, if the fill buffer completes in the same cycle as a handoff, it SHALL be presented on the next cycle.
REQ-035 Without BLOCK_FEEDER_DBUF_EN, the behaviour is single-buffer per REQ-016..REQ-026, with a maximum throughput of 1 vector per BLOCK_SIZE+1 cycles.

Structure
REQ-036 The state enum (FILL, PRESENT) and the localparam IDX_W=clog2(BLOCK_SIZE+1) SHALL reside in shared package block_pkg, alongside the calc-side types.
REQ-037 One sub-module, feeder_buf, SHALL hold one vector register pair with write-at-index, clear and full flag; it is instantiated once, or twice under BLOCK_FEEDER_DBUF_EN.

Verification (DATA_WIDTH=8, BLOCK_SIZE=3)
REQ-038 Feed (1,4),(2,5),(3,6) on consecutive cycles with out_ready=1 -> next cycle out_valid=1, A={1,2,3}, B={4,5,6}, and vec_count goes to 1 after the handoff.
REQ-039 Feed (7,9) with in_last=1 -> A={7,0,0}, B={9,0,0}, out_valid one cycle later.
REQ-040 Complete a vector, then hold out_ready=0 for 5 cycles -> A/B/out_valid stable and in_ready=0 (no DBUF); the handoff occurs on the cycle out_ready=1.
REQ-041 Accept 2 pairs, then pulse reset low for one cycle -> out_valid=0, A/B all 0, idx=0; the next 3 pairs form a fresh vector.
REQ-042 Under BLOCK_FEEDER_DBUF_EN, drive a continuous stream of 12 pairs with out_ready=1 -> 4 vectors, in_ready never deasserts after the first accept.
REQ-043 Preload vec_count to 0xFFFF by 65535 handoffs, then perform 1 more handoff -> vec_count=0x0000.
